// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage.
//
// Owns the fetch PC, issues word requests to instruction memory over a
// valid/ready request channel, and collects in-order responses. The
// responses go into a small registered FIFO. The FIFO head is presented
// downstream as {instr, instr_pc, instr_pc_plus4} under valid/ready.
// A redirect (taken branch/jump) flushes the FIFO, turns every request still
// in flight into a "drop" credit so its late response is discarded, and
// restarts fetch at the target.
//
// Parameters:
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  buffer entries (power of 2, >= 2); also caps requests in flight
//
// Ports:
//   clk, rst_n                        core clock, async active-low reset
//   imem_req_valid/ready/addr         fetch request channel (word-aligned addr)
//   imem_rsp_valid/data               in-order response channel
//   instr_valid/ready                 downstream handshake
//   instr, instr_pc, instr_pc_plus4   FIFO head word, its address, address + 4
//   redirect_valid/target             control-stage PC redirect
//   fetch_misalign                    sticky misaligned-redirect flag
//
// Build option:
//   FETCH_MISALIGN_CHECK_EN  when defined, a redirect target with [1:0] != 0
//                            sets fetch_misalign and parks the unit with fetch
//                            disabled until reset. When undefined, the low
//                            target bits are masked and fetch_misalign is 0.

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        fetch_misalign
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;        // address belonging to the next kept response
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] drop_next;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];

  logic          credit_ok;
  logic          req_fire;
  logic          rsp_drop;
  logic          rsp_keep;
  logic          push;
  logic          pop;
  logic          park;
  logic [31:0]   target_aligned;

  assign target_aligned = redirect_target & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;
  logic bad_target;

  assign bad_target     = redirect_valid && (redirect_target[1:0] != 2'b00);
  assign park           = misalign_q | bad_target;
  assign fetch_misalign = misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (bad_target) begin
      misalign_q <= 1'b1;
    end
  end
`else
  assign park           = 1'b0;
  assign fetch_misalign = 1'b0;
`endif

  // Credit: requests in flight plus buffered words never exceed the buffer
  // size, so every kept response always has a free slot.
  assign credit_ok      = ({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(FIFO_DEPTH);
  assign imem_req_valid = (state == S_FETCH) && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc & 32'hFFFF_FFFC;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop    = imem_rsp_valid && (drop != '0);
  assign rsp_keep    = imem_rsp_valid && (drop == '0);
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready;
  assign push        = rsp_keep && !redirect_valid;

  assign instr          = fifo_data[rd_ptr];
  assign instr_pc       = fifo_pc[rd_ptr];
  assign instr_pc_plus4 = instr_pc + 32'd4;

  // On redirect every request still in flight becomes a drop credit. A kept
  // response arriving in the redirect cycle has already returned, so it is
  // taken back out of that count. No request issues in a redirect cycle.
  always_comb begin
    drop_next = drop;
    if (rsp_drop) begin
      drop_next = drop_next - CW'(1);
    end
    if (redirect_valid) begin
      drop_next = drop_next + outstanding - CW'(rsp_keep);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_PC & 32'hFFFF_FFFC;
      rsp_pc      <= RESET_PC & 32'hFFFF_FFFC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      drop <= drop_next;
      if (redirect_valid) begin
        fetch_pc    <= target_aligned;
        rsp_pc      <= target_aligned;
        outstanding <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (rsp_keep) begin
          rsp_pc <= rsp_pc + 32'd4;
        end
        outstanding <= outstanding + CW'(req_fire) - CW'(rsp_keep);
      end

      unique case (state)
        S_IDLE: state <= park ? S_DRAIN : S_FETCH;
        S_FETCH: begin
          if (park || (redirect_valid && (outstanding != '0))) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!park && (drop_next == '0)) begin
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      // Flush: a same-cycle pop has already been taken by the consumer.
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= imem_rsp_data;
        fifo_pc[wr_ptr]   <= rsp_pc;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == CW'(FIFO_DEPTH))));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        fetch_misalign;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_pc_plus4  (instr_pc_plus4),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fetch_misalign  (fetch_misalign)
  );

  // One record per clock cycle: stimulus knobs and expected outputs.
  typedef struct {
    logic        rdy;      // imem_req_ready
    logic        rsp_en;   // memory may return its oldest pending word
    logic        iready;   // instr_ready
    logic        redir;
    logic [31:0] tgt;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] memq[$];
  int unsigned total = 0;
  int unsigned bad = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rdy, input logic rsp_en, input logic iready,
                     input logic redir, input logic [31:0] tgt,
                     input logic e_rv, input logic [31:0] e_addr,
                     input logic e_iv, input logic [31:0] e_pc);
    vec_t v;
    v.rdy = rdy; v.rsp_en = rsp_en; v.iready = iready; v.redir = redir; v.tgt = tgt;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc;
    vecs.push_back(v);
  endtask

  // Apply memory response for the current cycle (1-cycle minimum latency).
  task automatic mem_drive(input logic rsp_en);
    if (rsp_en && memq.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(memq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  initial begin
    vec_t v;

    // c0..c7: streaming from reset, 1-cycle memory
    add(1,1,1,0,0, 0,0,           0,0);
    add(1,1,1,0,0, 1,32'h0,       0,0);
    add(1,1,1,0,0, 1,32'h4,       0,0);
    add(1,1,1,0,0, 0,0,           1,32'h0);
    add(1,1,1,0,0, 1,32'h8,       1,32'h4);
    add(1,1,1,0,0, 1,32'hC,       0,0);
    add(1,1,1,0,0, 0,0,           1,32'h8);
    add(1,1,1,0,0, 1,32'h10,      1,32'hC);
    // c8..c17: consumer stalled, buffer fills to two words
    add(1,1,0,0,0, 1,32'h14,      0,0);
    for (int k = 0; k < 9; k++) add(1,1,0,0,0, 0,0, 1,32'h10);
    // c18..c22: consumer resumes, no loss or duplicate
    add(1,1,1,0,0, 0,0,           1,32'h10);
    add(1,1,1,0,0, 1,32'h18,      1,32'h14);
    add(1,1,1,0,0, 1,32'h1C,      0,0);
    add(1,1,1,0,0, 0,0,           1,32'h18);
    add(1,1,1,0,0, 1,32'h20,      1,32'h1C);
    // c23..c31: memory stalls, two in flight, redirect to 0x100, drain two
    add(1,0,1,0,0,           1,32'h24,  0,0);
    add(1,0,1,1,32'h100,     0,0,       0,0);
    add(1,1,1,0,0,           0,0,       0,0);
    add(1,1,1,0,0,           0,0,       0,0);
    add(1,1,1,0,0,           1,32'h100, 0,0);
    add(1,1,1,0,0,           1,32'h104, 0,0);
    add(1,1,1,0,0,           0,0,       1,32'h100);
    add(1,1,1,0,0,           1,32'h108, 1,32'h104);
    add(1,1,1,0,0,           1,32'h10C, 0,0);
    // c32..c36: redirect together with pop and response
    add(1,1,1,1,32'h200,     0,0,       1,32'h108);
    add(1,1,1,0,0,           0,0,       0,0);
    add(1,1,1,0,0,           1,32'h200, 0,0);
    add(1,1,1,0,0,           1,32'h204, 0,0);
    add(1,1,1,0,0,           0,0,       1,32'h200);
    // c37..c42: address wrap at top of memory
    add(1,1,1,1,32'hFFFF_FFF8, 0,0,             1,32'h204);
    add(1,1,1,0,0,             1,32'hFFFF_FFF8, 0,0);
    add(1,1,1,0,0,             1,32'hFFFF_FFFC, 0,0);
    add(1,1,1,0,0,             0,0,             1,32'hFFFF_FFF8);
    add(1,1,1,0,0,             1,32'h0,         1,32'hFFFF_FFFC);
    add(1,1,1,0,0,             1,32'h4,         0,0);
    // c43..c47: misaligned redirect target is masked
    add(1,1,1,1,32'h102,     0,0,       1,32'h0);
    add(1,1,1,0,0,           0,0,       0,0);
    add(1,1,1,0,0,           1,32'h100, 0,0);
    add(1,1,1,0,0,           1,32'h104, 0,0);
    add(1,1,1,0,0,           0,0,       1,32'h100);
    // c48..c52: request backpressure holds the address
    add(0,1,1,0,0,           1,32'h108, 1,32'h104);
    add(0,1,1,0,0,           1,32'h108, 0,0);
    add(1,1,1,0,0,           1,32'h108, 0,0);
    add(1,1,1,0,0,           1,32'h10C, 0,0);
    add(1,1,1,0,0,           0,0,       1,32'h108);

    // Reset values (asynchronous reset held)
    #2;
    chk("rst req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst instr", instr, 32'h0);
    chk("rst instr_pc", instr_pc, 32'h0);
    chk("rst pc_plus4", instr_pc_plus4, 32'h4);
    chk("rst misalign", {31'b0, fetch_misalign}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      imem_req_ready  = v.rdy;
      instr_ready     = v.iready;
      redirect_valid  = v.redir;
      redirect_target = v.tgt;
      mem_drive(v.rsp_en);
      @(negedge clk);
      chk($sformatf("c%0d req_valid", i), {31'b0, imem_req_valid}, {31'b0, v.e_rv});
      if (v.e_rv) chk($sformatf("c%0d req_addr", i), imem_req_addr, v.e_addr);
      chk($sformatf("c%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, v.e_iv});
      if (v.e_iv) begin
        chk($sformatf("c%0d instr_pc", i), instr_pc, v.e_pc);
        chk($sformatf("c%0d instr", i), instr, word_of(v.e_pc));
        chk($sformatf("c%0d pc_plus4", i), instr_pc_plus4, v.e_pc + 32'd4);
      end
      if (imem_req_valid && imem_req_ready) memq.push_back(imem_req_addr);
      @(posedge clk);
      #1;
    end
    chk("misalign tied off", {31'b0, fetch_misalign}, 32'd0);

    // Mid-transaction reset: outputs return to reset values immediately
    redirect_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("midrst instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("midrst instr_pc", instr_pc, 32'h0);
    chk("midrst pc_plus4", instr_pc_plus4, 32'h4);
    memq.delete();
    imem_rsp_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    for (int c = 0; c < 4; c++) begin
      mem_drive(1'b1);
      @(negedge clk);
      if (c == 1) chk("post-rst first addr", imem_req_addr, 32'h0);
      if (c == 3) begin
        chk("post-rst instr_valid", {31'b0, instr_valid}, 32'd1);
        chk("post-rst instr_pc", instr_pc, 32'h0);
      end
      if (imem_req_valid && imem_req_ready) memq.push_back(imem_req_addr);
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
